// File: rtl/hdmi_power_seq_if.sv
// Control/status bundle between the HDMI power sequencer and the top level.
// The master side is the sequencer; the slave side is the board-level logic.
interface hdmi_power_seq_if;
   logic       enable;
   logic       pll_locked;
   logic       pll_rst;
   logic       display_en;
   logic       fault;
   logic [2:0] state;
   logic [3:0] retry_cnt;
   logic [7:0] lock_loss_cnt;

   modport master (
      input  enable,
      input  pll_locked,
      output pll_rst,
      output display_en,
      output fault,
      output state,
      output retry_cnt,
      output lock_loss_cnt
   );

   modport slave (
      output enable,
      output pll_locked,
      input  pll_rst,
      input  display_en,
      input  fault,
      input  state,
      input  retry_cnt,
      input  lock_loss_cnt
   );
endinterface

// File: rtl/hdmi_power_seq.sv
// PLL reset / lock-qualification sequencer gating the HDMI display path.
// display_en rises only after a programmable run of uninterrupted lock.
module hdmi_power_seq #(
   parameter int unsigned PLL_RST_CYCLES = 16,
   parameter int unsigned LOCK_TIMEOUT   = 100000,
   parameter int unsigned STABLE_CYCLES  = 1024,
   parameter int unsigned MAX_RETRY      = 3,
   parameter int unsigned CNT_W          = 17
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   hdmi_power_seq_if.master bus
);

   typedef enum logic [2:0] {
      StIdle     = 3'd0,
      StRstPll   = 3'd1,
      StWaitLock = 3'd2,
      StStable   = 3'd3,
      StRun      = 3'd4,
      StFault    = 3'd5
   } state_e;

   localparam logic [CNT_W-1:0] RstLast    = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] LockLast   = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] StableLast = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [3:0]       MaxRetry   = 4'(MAX_RETRY);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] timer_q, timer_d;
   logic [3:0]       retry_q, retry_d;
   logic [7:0]       loss_q, loss_d;
   logic [1:0]       sync_q, sync_d;
   logic             pll_rst_q, pll_rst_d;
   logic             display_en_q, display_en_d;
   logic             fault_q, fault_d;
   logic             locked_s;
   logic [3:0]       retry_inc;

   assign locked_s  = sync_q[1];
   assign retry_inc = retry_q + 4'd1;

   always_comb begin
      state_d = state_q;
      retry_d = retry_q;
      loss_d  = loss_q;
      sync_d  = {sync_q[0], bus.pll_locked};

      if (!bus.enable) begin
         state_d = StIdle;
         retry_d = '0;
      end else begin
         unique case (state_q)
            StIdle:     state_d = StRstPll;
            StRstPll:   if (timer_q == RstLast) state_d = StWaitLock;
            StWaitLock: begin
               // Lock seen in the timeout cycle wins over the retry.
               if (locked_s) begin
                  state_d = StStable;
               end else if (timer_q == LockLast) begin
                  retry_d = retry_inc;
                  state_d = (retry_inc == MaxRetry) ? StFault : StRstPll;
               end
            end
            StStable: begin
               if (!locked_s) begin
                  state_d = StWaitLock;
               end else if (timer_q == StableLast) begin
                  state_d = StRun;
                  retry_d = '0;
               end
            end
            StRun: begin
               if (!locked_s) begin
                  state_d = StRstPll;
                  if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
               end
            end
            StFault: state_d = StFault;
            default: state_d = StIdle;
         endcase
      end

      timer_d = (state_d != state_q) ? '0 : timer_q + CNT_W'(1);

      // Outputs decode the next state so they switch together with state_q.
      pll_rst_d    = (state_d == StIdle) || (state_d == StRstPll) || (state_d == StFault);
      display_en_d = (state_d == StRun);
      fault_d      = (state_d == StFault);
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q      <= StIdle;
         timer_q      <= '0;
         retry_q      <= '0;
         loss_q       <= '0;
         sync_q       <= '0;
         pll_rst_q    <= 1'b1;
         display_en_q <= 1'b0;
         fault_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         timer_q      <= timer_d;
         retry_q      <= retry_d;
         loss_q       <= loss_d;
         sync_q       <= sync_d;
         pll_rst_q    <= pll_rst_d;
         display_en_q <= display_en_d;
         fault_q      <= fault_d;
      end
   end

   assign bus.state         = state_q;
   assign bus.pll_rst       = pll_rst_q;
   assign bus.display_en    = display_en_q;
   assign bus.fault         = fault_q;
   assign bus.retry_cnt     = retry_q;
   assign bus.lock_loss_cnt = loss_q;

endmodule

// File: doc/hdmi_power_seq.md
Name: hdmi_power_seq

Overview:
- Power-up and recovery sequencer for the HDMI output path; clocked from the free-running 50 MHz board clock.
- Drives the pixel/serial PLL reset and holds the display path (display_hvscan, HDMI_top) disabled until the PLL has been locked continuously for a programmable time.
- On lock loss it drops display_en, retries the PLL with bounded attempts, and latches a fault when the retries are exhausted.
- Replaces the direct use of pll_locked as display enable in the top level.

Parameters:
- PLL_RST_CYCLES, 16: cycles pll_rst is held high per reset pulse (min 1).
- LOCK_TIMEOUT, 100000: cycles allowed in WAIT_LOCK before a retry (2 ms at 50 MHz).
- STABLE_CYCLES, 1024: consecutive synchronized-lock cycles required before RUN.
- MAX_RETRY, 3: failed lock attempts before FAULT (1..15).
- CNT_W, 17: width of the shared timer; must hold max(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES).

Ports:
- sys_clk, input, 1: free-running board clock; sole clock.
- sys_rst, input, 1: synchronous active-high reset.
- enable, input, 1: level; 1 requests the display path up, 0 forces it down.
- pll_locked, input, 1: PLL LOCKED, asynchronous to sys_clk.
- pll_rst, output, 1: to PLLE2 RST.
- display_en, output, 1: to display_hvscan/HDMI_top enable; the consumer synchronizes it into pixel_clk.
- fault, output, 1: retries exhausted.
- state, output, 3: current state code.
- retry_cnt, output, 4: failed attempts since the last successful RUN entry or IDLE.
- lock_loss_cnt, output, 8: number of RUN-to-lock-loss events; saturates at 255.

Behaviour:
- Interface: one clock (sys_clk); reset is synchronous and active-high (sys_rst). All flops clear on sys_rst.
- pll_locked passes through a 2-flop synchronizer to give locked_s (2-cycle latency). Only locked_s is used internally.
- Outputs are registered; they are Moore decodes of the state register and change in the same cycle the state changes.
- State codes: IDLE=0, RST_PLL=1, WAIT_LOCK=2, STABLE=3, RUN=4, FAULT=5.
- Reset values: state=IDLE, pll_rst=1, display_en=0, fault=0, retry_cnt=0, lock_loss_cnt=0, timer=0, synchronizer=0.
- pll_rst=1 in IDLE, RST_PLL and FAULT; 0 otherwise. display_en=1 only in RUN. fault=1 only in FAULT.
- The timer clears on every state change; otherwise it increments each cycle.
- enable=0 in any state: next state is IDLE and retry_cnt clears. This has priority over all other transitions. lock_loss_cnt is kept.
- IDLE: enable=1 -> RST_PLL.
- RST_PLL: stays exactly PLL_RST_CYCLES cycles (timer==PLL_RST_CYCLES-1), then -> WAIT_LOCK.
- WAIT_LOCK:
  - locked_s=1 -> STABLE.
  - Otherwise, at timer==LOCK_TIMEOUT-1, retry_cnt increments. If the new value equals MAX_RETRY -> FAULT, else -> RST_PLL.
  - If locked_s rises in the timeout cycle, lock wins: -> STABLE, no increment.
- STABLE:
  - locked_s=0 -> WAIT_LOCK; the timeout restarts and retry_cnt is unchanged.
  - locked_s=1 at timer==STABLE_CYCLES-1 -> RUN and retry_cnt clears. display_en therefore rises after exactly STABLE_CYCLES consecutive locked_s=1 cycles in STABLE.
- RUN: locked_s=0 -> RST_PLL next cycle; display_en falls in that cycle; lock_loss_cnt increments (saturating); retry_cnt stays 0.
- FAULT: sticky. The only exits are enable=0 (-> IDLE) or sys_rst. Toggling enable 1->0->1 therefore retries from scratch.
- sys_rst mid-operation: outputs return to reset values in the next cycle regardless of state; pll_rst asserts immediately from the reset values.
- Glitches on pll_locked shorter than 1 cycle may or may not be seen; any locked_s=0 cycle counts as lock loss.

Test Plan (PLL_RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRY=2):
- Nominal bring-up: sys_rst, then enable=1 and pll_locked rising 3 cycles after pll_rst falls -> pll_rst high for exactly 4 cycles; state 2 then 3; display_en rises exactly 8 cycles after entering STABLE; retry_cnt=0.
- Timeout and fault: pll_locked held 0 -> two 20-cycle WAIT_LOCK windows; retry_cnt reads 1 then 2; state=5, fault=1, pll_rst=1. Dropping enable for 1 cycle -> IDLE with fault=0 and retry_cnt=0.
- Unstable lock: pll_locked high 5 cycles, low 1, then high -> return to WAIT_LOCK without a retry increment; RUN reached 8 cycles after the second STABLE entry.
- Lock loss in RUN: pll_locked dropped in RUN -> display_en=0 and pll_rst=1 3 cycles later (2 sync + 1); lock_loss_cnt=1; re-lock -> RUN again. Repeat 300 times -> lock_loss_cnt saturates at 255.
- Simultaneous events: pll_locked rising so locked_s=1 in the timeout cycle -> STABLE, retry_cnt unchanged. enable=0 in the same cycle as the STABLE->RUN condition -> IDLE, display_en never asserts.
- Reset mid-RUN: sys_rst pulsed for 1 cycle -> next cycle state=0, display_en=0, pll_rst=1, lock_loss_cnt=0.
